brisc_v_run_controller: RTL and testbench

Hardware run sequencer for a BRISC-V core with a BRAM-backed program memory. On a host request it resets the core and issues the one-cycle `start` with a program address. It then counts execution cycles until the fetch PC reaches a halt address, waits for the pipeline to drain, and samples the result register to report pass/fail. It sits between a host/scan interface and the core's `reset`/`start`/`program_address` inputs, with taps on the fetch PC and one register-file read port.

---
 rtl/brisc_v_run_controller_if.sv | 34 +++
 rtl/brisc_v_run_controller.sv | 146 ++++++++++++++
 tb/tb_brisc_v_run_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/brisc_v_run_controller_if.sv
// Host/core-facing signal bundle of the BRISC-V run controller.
// The host/core side takes the master view and the controller takes the slave view.
interface brisc_v_run_controller_if #(
    parameter int ADDRESS_BITS = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int CYCLE_BITS   = 32
);
    logic                    run_req;
    logic [ADDRESS_BITS-1:0] run_address;
    logic [DATA_WIDTH-1:0]   expected_value;
    logic [ADDRESS_BITS-1:0] core_pc;
    logic [DATA_WIDTH-1:0]   reg_read_data;
    logic [4:0]              reg_read_index;
    logic                    core_reset;
    logic                    core_start;
    logic [ADDRESS_BITS-1:0] core_program_address;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    timeout;
    logic [CYCLE_BITS-1:0]   cycles;

    modport master (
        output run_req, run_address, expected_value, core_pc, reg_read_data,
        input  reg_read_index, core_reset, core_start, core_program_address,
               busy, done, pass, timeout, cycles
    );

    modport slave (
        input  run_req, run_address, expected_value, core_pc, reg_read_data,
        output reg_read_index, core_reset, core_start, core_program_address,
               busy, done, pass, timeout, cycles
    );
endinterface

// File: rtl/brisc_v_run_controller.sv
// Run sequencer: resets and starts the core, times the run up to a halt PC,
// lets the pipeline drain, then compares the result register with a golden value.
module brisc_v_run_controller #(
    parameter int                 ADDRESS_BITS   = 32,
    parameter int                 DATA_WIDTH     = 32,
    parameter int                 CYCLE_BITS     = 32,
    parameter logic [ADDRESS_BITS-1:0] HALT_PC_A = 32'h000000b0,
    parameter logic [ADDRESS_BITS-1:0] HALT_PC_B = 32'h000000b4,
    parameter int                 RESULT_REG     = 9,
    parameter int                 RESET_CYCLES   = 5,
    parameter int                 DRAIN_CYCLES   = 50,
    parameter int                 TIMEOUT_CYCLES = 100000
) (
    input logic                     clock,
    input logic                     reset,
    brisc_v_run_controller_if.slave bus
);
    localparam int DELAY_MAX  = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int DELAY_BITS = $clog2(DELAY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_CORE, S_START, S_RUN, S_DRAIN, S_CHECK, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [DELAY_BITS-1:0]   delay_q, delay_d;
    logic [CYCLE_BITS-1:0]   cycle_q, cycle_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   expected_q, expected_d;
    logic [CYCLE_BITS-1:0]   cycles_q, cycles_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic                    core_reset_q, core_reset_d;
    logic                    core_start_q, core_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    halt_hit;

    assign halt_hit = (bus.core_pc == HALT_PC_A) || (bus.core_pc == HALT_PC_B);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            delay_q      <= '0;
            cycle_q      <= '0;
            addr_q       <= '0;
            expected_q   <= '0;
            cycles_q     <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            core_reset_q <= 1'b1;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            cycle_q      <= cycle_d;
            addr_q       <= addr_d;
            expected_q   <= expected_d;
            cycles_q     <= cycles_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // NOTE: every signal gets a default at the top so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        cycle_d    = cycle_q;
        addr_d     = addr_q;
        expected_d = expected_q;
        cycles_d   = cycles_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.run_req) begin
                    addr_d     = bus.run_address;
                    expected_d = bus.expected_value;
                    delay_d    = DELAY_BITS'(RESET_CYCLES);
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_RESET_CORE;
                end
            end
            S_RESET_CORE: begin
                delay_d = delay_q - DELAY_BITS'(1);
                if (delay_q == DELAY_BITS'(1)) state_d = S_START;
            end
            S_START: begin
                cycle_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_d = cycle_q + CYCLE_BITS'(1);
                // Halt takes priority over a timeout landing in the same cycle.
                if (halt_hit) begin
                    cycles_d = cycle_q;
                    delay_d  = DELAY_BITS'(DRAIN_CYCLES);
                    state_d  = S_DRAIN;
                end else if (cycle_q == CYCLE_BITS'(TIMEOUT_CYCLES - 1)) begin
                    cycles_d  = CYCLE_BITS'(TIMEOUT_CYCLES);
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DRAIN: begin
                delay_d = delay_q - DELAY_BITS'(1);
                if (delay_q == DELAY_BITS'(1)) state_d = S_CHECK;
            end
            S_CHECK: begin
                pass_d    = (bus.reg_read_data == expected_q);
                timeout_d = 1'b0;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs are registered versions of a decode of the next state.
    always_comb begin
        core_reset_d = (state_d == S_IDLE) || (state_d == S_RESET_CORE);
        core_start_d = (state_d == S_START);
        busy_d       = state_d inside {S_RESET_CORE, S_START, S_RUN, S_DRAIN, S_CHECK};
        done_d       = (state_d == S_DONE);
    end

    assign bus.reg_read_index       = 5'(RESULT_REG);
    assign bus.core_reset           = core_reset_q;
    assign bus.core_start           = core_start_q;
    assign bus.core_program_address = addr_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
    assign bus.pass                 = pass_q;
    assign bus.timeout              = timeout_q;
    assign bus.cycles               = cycles_q;
endmodule

// File: tb/tb_brisc_v_run_controller.sv
// Directed bench for brisc_v_run_controller: one default instance and one with a
// 20-cycle run limit, selected by sel, driven by a cycle-exact core model.
module tb_brisc_v_run_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel   = 1'b0;
    logic        run_req = 1'b0;
    logic [31:0] run_address = '0;
    logic [31:0] expected_value = '0;
    logic [31:0] core_pc = '0;
    logic [31:0] reg_read_data = '0;
    int          n_total = 0;
    int          n_bad = 0;

    always #5 clock = ~clock;

    brisc_v_run_controller_if bus_n ();
    brisc_v_run_controller_if bus_t ();

    assign bus_n.run_req        = run_req & ~sel;
    assign bus_t.run_req        = run_req & sel;
    assign bus_n.run_address    = run_address;
    assign bus_t.run_address    = run_address;
    assign bus_n.expected_value = expected_value;
    assign bus_t.expected_value = expected_value;
    assign bus_n.core_pc        = core_pc;
    assign bus_t.core_pc        = core_pc;
    assign bus_n.reg_read_data  = reg_read_data;
    assign bus_t.reg_read_data  = reg_read_data;

    brisc_v_run_controller dut_n (.clock(clock), .reset(reset), .bus(bus_n));
    brisc_v_run_controller #(.TIMEOUT_CYCLES(20)) dut_t (.clock(clock), .reset(reset), .bus(bus_t));

    logic        o_core_reset, o_core_start, o_busy, o_done, o_pass, o_timeout;
    logic [31:0] o_addr, o_cycles;
    logic [4:0]  o_index;
    assign o_core_reset = sel ? bus_t.core_reset : bus_n.core_reset;
    assign o_core_start = sel ? bus_t.core_start : bus_n.core_start;
    assign o_busy       = sel ? bus_t.busy       : bus_n.busy;
    assign o_done       = sel ? bus_t.done       : bus_n.done;
    assign o_pass       = sel ? bus_t.pass       : bus_n.pass;
    assign o_timeout    = sel ? bus_t.timeout    : bus_n.timeout;
    assign o_addr       = sel ? bus_t.core_program_address : bus_n.core_program_address;
    assign o_cycles     = sel ? bus_t.cycles     : bus_n.cycles;
    assign o_index      = sel ? bus_t.reg_read_index : bus_n.reg_read_index;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, o_core_reset, 1);
        check({tag, "_core_start"}, o_core_start, 0);
        check({tag, "_busy"},       o_busy, 0);
        check({tag, "_done"},       o_done, 0);
        check({tag, "_pass"},       o_pass, 0);
        check({tag, "_timeout"},    o_timeout, 0);
        check({tag, "_cycles"},     o_cycles, 0);
        check({tag, "_addr"},       o_addr, 0);
        check({tag, "_index"},      o_index, 9);
    endtask

    // Request at edge T; returns in the first RUN cycle (T+7).
    task automatic start_run(input logic [31:0] addr, input logic [31:0] expv, input logic hold);
        run_req        = 1'b1;
        run_address    = addr;
        expected_value = expv;
        core_pc        = 32'h0;
        tick();
        if (hold) run_address = 32'h0000_0bad;
        else      run_req = 1'b0;
        check("req_busy", o_busy, 1);
        check("req_done", o_done, 0);
        check("req_pass", o_pass, 0);
        check("req_timeout", o_timeout, 0);
        check("req_addr", o_addr, addr);
        for (int i = 0; i < 5; i++) begin
            check("rst_hold_reset", o_core_reset, 1);
            check("rst_hold_start", o_core_start, 0);
            tick();
        end
        check("start_pulse", o_core_start, 1);
        check("start_core_reset", o_core_reset, 0);
        tick();
        check("run0_start_low", o_core_start, 0);
        check("run0_busy", o_busy, 1);
    endtask

    // Core model: PC walks from 0x100, showing halt_pc in RUN cycle halt_at.
    task automatic run_core(input int halt_at, input logic [31:0] halt_pc, input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            core_pc = (k == halt_at) ? halt_pc : 32'h100 + 32'(4 * k);
            tick();
            if (k == halt_at) break;
        end
    endtask

    // Entered in cycle H+1; returns in cycle H+52.
    task automatic finish_drain();
        check("drain_busy", o_busy, 1);
        check("drain_done", o_done, 0);
        core_pc = 32'h0000_00b0;
        repeat (50) tick();
        check("check_done_low", o_done, 0);
        tick();
    endtask

    task automatic check_result(input logic exp_pass, input logic exp_timeout,
                                input logic [31:0] exp_cycles, input logic [31:0] exp_addr);
        check("res_done", o_done, 1);
        check("res_busy", o_busy, 0);
        check("res_pass", o_pass, exp_pass);
        check("res_timeout", o_timeout, exp_timeout);
        check("res_cycles", o_cycles, exp_cycles);
        check("res_addr", o_addr, exp_addr);
        check("res_core_reset", o_core_reset, 0);
        check("res_core_start", o_core_start, 0);
    endtask

    initial begin
        #12;
        sel = 1'b0;
        #1 check_reset_values("por_n");
        sel = 1'b1;
        #1 check_reset_values("por_t");
        sel = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        check("idle_core_reset", o_core_reset, 1);
        check("idle_busy", o_busy, 0);

        // Nominal run: halt at 0xb0 in RUN cycle 37, result matches.
        reg_read_data = 32'h10;
        start_run(32'h0, 32'h10, 1'b0);
        run_core(37, 32'h0000_00b0, 38);
        finish_drain();
        check_result(1'b1, 1'b0, 32'd37, 32'h0);

        // Wrong result register value.
        reg_read_data = 32'h0f;
        start_run(32'h0, 32'h10, 1'b0);
        run_core(37, 32'h0000_00b0, 38);
        finish_drain();
        check_result(1'b0, 1'b0, 32'd37, 32'h0);

        // Halt on B in the same cycle the 20-cycle limit is reached.
        sel = 1'b1;
        reg_read_data = 32'h10;
        start_run(32'h0, 32'h10, 1'b0);
        run_core(19, 32'h0000_00b4, 20);
        finish_drain();
        check_result(1'b1, 1'b0, 32'd19, 32'h0);

        // Timeout: no halt PC ever seen, DONE right after the limit.
        start_run(32'h0, 32'h10, 1'b0);
        run_core(-1, 32'h0, 20);
        check_result(1'b0, 1'b1, 32'd20, 32'h0);

        // run_req held through a run, then a back-to-back run from DONE.
        sel = 1'b0;
        start_run(32'h0, 32'h10, 1'b1);
        run_core(37, 32'h0000_00b0, 38);
        finish_drain();
        check_result(1'b1, 1'b0, 32'd37, 32'h0);
        start_run(32'h40, 32'h10, 1'b0);
        run_core(3, 32'h0000_00b4, 4);
        finish_drain();
        check_result(1'b1, 1'b0, 32'd3, 32'h40);

        // Asynchronous reset in DRAIN, then a clean run.
        start_run(32'h80, 32'h10, 1'b0);
        run_core(5, 32'h0000_00b0, 6);
        repeat (3) tick();
        check("pre_reset_cycles", o_cycles, 5);
        #3 reset = 1'b1;
        #1 check_reset_values("midrun");
        @(posedge clock);
        #1 reset = 1'b0;
        tick();
        check("post_reset_busy", o_busy, 0);
        check("post_reset_core_reset", o_core_reset, 1);
        start_run(32'h0, 32'h10, 1'b0);
        run_core(10, 32'h0000_00b0, 11);
        finish_drain();
        check_result(1'b1, 1'b0, 32'd10, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
